// File: rtl/ahb_sram_slave.sv
// AHB-Lite memory responder: word-addressed on-chip SRAM behind one slave window,
// with programmable wait states and a two-cycle ERROR response for illegal transfers.
module ahb_sram_slave #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'hEEEE_0000),
    parameter int unsigned           MEM_DEPTH   = 256,
    parameter int unsigned           WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int unsigned           IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned           CNT_W     = 4;
    localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [IDX_W-1:0]      lat_idx;
    logic [1:0]            lat_lane;
    logic [1:0]            lat_size;
    logic                  lat_write;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] offset_c;
    logic                  accept_c;
    logic                  illegal_c;
    logic                  wr_commit_c;
    logic [IDX_W-1:0]      rd_idx_c;
    logic [3:0]            be_c;
    logic [DATA_WIDTH-1:0] wr_word_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic                  hreadyout_nxt;
    logic                  hresp_nxt;
    logic [DATA_WIDTH-1:0] hrdata_nxt;
    logic                  unused_c;

    // HBURST and HTRANS[0] carry no information for a beat-by-beat responder
    assign unused_c = ^{HBURST, HTRANS[0]};

    assign offset_c  = HADDR - BASE_ADDR;
    assign accept_c  = HSEL && HREADY && HTRANS[1] &&
                       (state == S_IDLE || state == S_DATA || state == S_ERR2);
    assign illegal_c = (offset_c >= WIN_BYTES) || (HSIZE > 3'b010) ||
                       (HSIZE == 3'b001 && HADDR[0]) ||
                       (HSIZE == 3'b010 && HADDR[1:0] != 2'b00);

    assign wr_commit_c = (state == S_DATA) && lat_write;

    // Lane-merged word that the current write data phase commits
    always_comb begin
        be_c      = 4'b0000;
        wr_word_c = mem[lat_idx];
        case (lat_size)
            2'b00:   be_c[lat_lane] = 1'b1;
            2'b01:   be_c = lat_lane[1] ? 4'b1100 : 4'b0011;
            default: be_c = 4'b1111;
        endcase
        for (int b = 0; b < 4; b++) begin
            if (be_c[b]) begin
                wr_word_c[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    // A read entering DATA straight from its address phase may hit the word being written now
    assign rd_idx_c  = (state == S_WAIT) ? lat_idx : offset_c[IDX_W+1:2];
    assign rd_word_c = (wr_commit_c && lat_idx == rd_idx_c) ? wr_word_c : mem[rd_idx_c];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = S_DATA;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_ERR1: state_nxt = S_ERR2;
            default: begin
                state_nxt = S_IDLE;
                if (accept_c) begin
                    if (illegal_c) begin
                        state_nxt = S_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_nxt = S_DATA;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
        endcase
        hreadyout_nxt = !(state_nxt == S_WAIT || state_nxt == S_ERR1);
        hresp_nxt     = (state_nxt == S_ERR1 || state_nxt == S_ERR2);
        hrdata_nxt    = (state_nxt == S_DATA) ? rd_word_c : '0;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_lane  <= '0;
            lat_size  <= '0;
            lat_write <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            HREADYOUT <= hreadyout_nxt;
            HRESP     <= hresp_nxt;
            HRDATA    <= hrdata_nxt;
            if (accept_c) begin
                lat_idx   <= offset_c[IDX_W+1:2];
                lat_lane  <= HADDR[1:0];
                lat_size  <= HSIZE[1:0];
                lat_write <= HWRITE && !illegal_c;
            end
        end
    end

    // SRAM array is deliberately left out of reset
    always_ff @(posedge HCLK) begin
        if (wr_commit_c) begin
            mem[lat_idx] <= wr_word_c;
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance with one wait state, one with none, driven
// by a pipelined AHB master and checked against a per-instance memory model.
module tb_ahb_sram_slave;

    localparam logic [31:0] BASE = 32'hEEEE_0000;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic        sel;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        hreset;
    logic        hsel_a, hsel_b;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hreadyout_a, hresp_a, hreadyout_b, hresp_b;
    logic [31:0] hrdata_a, hrdata_b;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] mdl [2][256];
    xfer_t       q[$];

    always #5 clk = ~clk;

    ahb_sram_slave #(.WAIT_STATES(1)) dut_a (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel_a), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hreadyout_a), .HREADYOUT(hreadyout_a), .HRESP(hresp_a), .HRDATA(hrdata_a)
    );

    ahb_sram_slave #(.WAIT_STATES(0)) dut_b (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel_b), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hreadyout_b), .HREADYOUT(hreadyout_b), .HRESP(hresp_b), .HRDATA(hrdata_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] lane, input logic [2:0] size);
        logic [31:0] r;
        r = old;
        if (size == 3'd0)      r[8*lane +: 8] = wd[8*lane +: 8];
        else if (size == 3'd1) r[16*lane[1] +: 16] = wd[16*lane[1] +: 16];
        else                   r = wd;
        return r;
    endfunction

    task automatic add(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                       input logic [1:0] trans, input logic sel, input logic [31:0] wdata);
        xfer_t x;
        x.addr = addr; x.wr = wr; x.size = size; x.trans = trans; x.sel = sel; x.wdata = wdata;
        q.push_back(x);
    endtask

    task automatic drive_addr(input int cur, input xfer_t x, input bit valid);
        hsel_a = valid && cur == 0 && x.sel;
        hsel_b = valid && cur == 1 && x.sel;
        haddr  = valid ? x.addr : 32'h0;
        htrans = valid ? x.trans : 2'b00;
        hwrite = valid ? x.wr : 1'b0;
        hsize  = valid ? x.size : 3'b000;
        hburst = 3'($urandom_range(0, 7));
    endtask

    // One bus cycle: compare the selected responder's outputs mid-cycle, then advance
    task automatic cycle(input int cur, input string tag, input logic ro, input logic rs,
                         input logic [31:0] rd, input bit chk_rd);
        @(negedge clk);
        chk({tag, ".hreadyout"}, 32'(cur == 1 ? hreadyout_b : hreadyout_a), 32'(ro));
        chk({tag, ".hresp"}, 32'(cur == 1 ? hresp_b : hresp_a), 32'(rs));
        if (chk_rd) chk({tag, ".hrdata"}, cur == 1 ? hrdata_b : hrdata_a, rd);
        @(posedge clk);
        #1;
    endtask

    // Expected data-phase behaviour of one transfer, from the protocol rules
    task automatic phase(input int cur, input xfer_t x);
        logic [31:0] off, word;
        bit          err;
        int          ws;
        ws   = (cur == 0) ? 1 : 0;
        off  = x.addr - BASE;
        err  = (off >= 32'd1024) || (x.size > 3'd2) ||
               (x.size == 3'd1 && x.addr[0]) || (x.size == 3'd2 && x.addr[1:0] != 2'b00);
        if (!(x.sel && x.trans[1])) begin
            cycle(cur, "idle", 1'b1, 1'b0, 32'h0, 1'b1);
        end else if (err) begin
            cycle(cur, "err1", 1'b0, 1'b1, 32'h0, 1'b1);
            cycle(cur, "err2", 1'b1, 1'b1, 32'h0, 1'b1);
        end else begin
            word = mdl[cur][off[9:2]];
            for (int w = 0; w < ws; w++) cycle(cur, "wait", 1'b0, 1'b0, 32'h0, 1'b1);
            cycle(cur, x.wr ? "wdata" : "rdata", 1'b1, 1'b0, word, !x.wr);
            if (x.wr) mdl[cur][off[9:2]] = merge(word, x.wdata, x.addr[1:0], x.size);
        end
    endtask

    // Issue the queued transfers back to back, address of N+1 overlapping data of N
    task automatic run(input int cur);
        xfer_t dp;
        bit    dp_v;
        dp_v = 1'b0;
        for (int i = 0; i <= q.size(); i++) begin
            drive_addr(cur, (i < q.size()) ? q[i] : dp, i < q.size());
            hwdata = (dp_v && dp.wr) ? dp.wdata : $urandom;
            if (dp_v) phase(cur, dp);
            else begin
                @(posedge clk);
                #1;
            end
            if (i < q.size()) begin
                dp   = q[i];
                dp_v = 1'b1;
            end
        end
        q.delete();
    endtask

    function automatic xfer_t rnd_xfer();
        xfer_t      x;
        logic [1:0] lane;
        int         k;
        k      = $urandom_range(0, 19);
        x.size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        lane   = 2'($urandom_range(0, 3));
        if (x.size == 3'd1 && $urandom_range(0, 4) != 0) lane[0] = 1'b0;
        if (x.size == 3'd2 && $urandom_range(0, 4) != 0) lane = 2'b00;
        if (k == 0)      x.addr = BASE + 32'h400 + 32'($urandom_range(0, 255)) * 4 + 32'(lane);
        else if (k == 1) x.addr = BASE - 32'h10 + 32'(lane);
        else             x.addr = BASE + 32'($urandom_range(0, 15)) * 4 + 32'(lane);
        k       = $urandom_range(0, 9);
        x.trans = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'($urandom_range(2, 3));
        x.sel   = ($urandom_range(0, 9) != 0);
        x.wr    = 1'($urandom_range(0, 1));
        x.wdata = $urandom;
        return x;
    endfunction

    initial begin
        xfer_t x;
        hreset = 1'b1;
        x.addr = 32'h0; x.wr = 1'b0; x.size = 3'd0; x.trans = 2'b00; x.sel = 1'b0; x.wdata = 32'h0;
        drive_addr(0, x, 1'b0);
        hwdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.a.hreadyout", 32'(hreadyout_a), 32'd1);
        chk("reset.a.hresp", 32'(hresp_a), 32'd0);
        chk("reset.a.hrdata", hrdata_a, 32'h0);
        chk("reset.b.hreadyout", 32'(hreadyout_b), 32'd1);
        chk("reset.b.hresp", 32'(hresp_b), 32'd0);
        chk("reset.b.hrdata", hrdata_b, 32'h0);
        @(posedge clk);
        #1 hreset = 1'b0;

        // Known contents for the low 16 words of both memories
        for (int c = 0; c < 2; c++) begin
            for (int w = 0; w < 16; w++) add(BASE + 32'(w * 4), 1'b1, 3'd2, 2'b10, 1'b1, 32'h0);
            run(c);
        end

        // Word write then read-back with one wait state
        add(BASE + 32'h10, 1'b1, 3'd2, 2'b10, 1'b1, 32'hDEADBEEF);
        add(BASE + 32'h10, 1'b0, 3'd2, 2'b10, 1'b1, 32'h0);
        run(0);

        // Byte and halfword lane merging
        add(BASE + 32'h20, 1'b1, 3'd2, 2'b10, 1'b1, 32'h11223344);
        add(BASE + 32'h22, 1'b1, 3'd0, 2'b10, 1'b1, 32'h00AA0000);
        add(BASE + 32'h20, 1'b1, 3'd1, 2'b10, 1'b1, 32'h00005566);
        add(BASE + 32'h20, 1'b0, 3'd2, 2'b10, 1'b1, 32'h0);
        run(0);
        chk("lanes.model", mdl[0][8], 32'h11AA5566);

        // Out of window, misaligned halfword, oversized transfer
        add(BASE + 32'h400, 1'b0, 3'd2, 2'b10, 1'b1, 32'h0);
        add(BASE + 32'h001, 1'b1, 3'd1, 2'b10, 1'b1, 32'hFFFFFFFF);
        add(BASE + 32'h020, 1'b1, 3'd3, 2'b10, 1'b1, 32'hFFFFFFFF);
        add(BASE + 32'h020, 1'b0, 3'd2, 2'b10, 1'b1, 32'h0);
        add(BASE + 32'h000, 1'b0, 3'd2, 2'b10, 1'b1, 32'h0);
        run(0);

        // Zero-wait back-to-back write then read of the same word
        add(BASE + 32'h04, 1'b1, 3'd2, 2'b10, 1'b1, 32'h000000FF);
        add(BASE + 32'h04, 1'b0, 3'd2, 2'b10, 1'b1, 32'h0);
        run(1);

        // IDLE with HSEL high and BUSY inside a burst
        for (int c = 0; c < 2; c++) begin
            add(BASE + 32'h30, 1'b1, 3'd2, 2'b00, 1'b1, 32'hFFFFFFFF);
            add(BASE + 32'h30, 1'b1, 3'd2, 2'b10, 1'b1, 32'h0A0B0C0D);
            add(BASE + 32'h34, 1'b1, 3'd2, 2'b01, 1'b1, 32'hFFFFFFFF);
            add(BASE + 32'h34, 1'b1, 3'd2, 2'b11, 1'b1, 32'h01020304);
            add(BASE + 32'h30, 1'b0, 3'd2, 2'b10, 1'b1, 32'h0);
            add(BASE + 32'h34, 1'b0, 3'd2, 2'b10, 1'b1, 32'h0);
            run(c);
        end

        // Reset during the wait cycle of a write drops it
        x.addr = BASE + 32'h08; x.wr = 1'b1; x.size = 3'd2; x.trans = 2'b10; x.sel = 1'b1;
        x.wdata = 32'h12345678;
        drive_addr(0, x, 1'b1);
        @(posedge clk);
        #1;
        x.sel = 1'b0;
        drive_addr(0, x, 1'b0);
        hwdata = 32'h12345678;
        chk("rst.wait.hreadyout", 32'(hreadyout_a), 32'd0);
        #2 hreset = 1'b1;
        #1;
        chk("rst.async.hreadyout", 32'(hreadyout_a), 32'd1);
        chk("rst.async.hresp", 32'(hresp_a), 32'd0);
        chk("rst.async.hrdata", hrdata_a, 32'h0);
        @(posedge clk);
        #1 hreset = 1'b0;
        add(BASE + 32'h08, 1'b0, 3'd2, 2'b10, 1'b1, 32'h0);
        run(0);

        // Randomized traffic on both responders
        for (int c = 0; c < 2; c++) begin
            for (int n = 0; n < 120; n++) q.push_back(rnd_xfer());
            run(c);
        end
        for (int c = 0; c < 2; c++) begin
            for (int w = 0; w < 16; w++) add(BASE + 32'(w * 4), 1'b0, 3'd2, 2'b10, 1'b1, 32'h0);
            run(c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite responder that terminates one slave window of the bus address map with an on-chip word-addressed SRAM.
- Instantiated once per memory-type slave behind the decoder and slave-side mux.
- Provides a pipelined address/data phase, programmable wait states, byte/halfword/word access, and a two-cycle ERROR response for illegal transfers.

Parameters:
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA width. Only 32 is supported.
- BASE_ADDR, 32'hEEEE_0000, first byte address of the window. Offset = HADDR - BASE_ADDR.
- MEM_DEPTH, 256, number of DATA_WIDTH words. Must be a power of two.
- WAIT_STATES, 1, HREADYOUT-low cycles inserted in every legal NONSEQ/SEQ data phase. Range 0..15.

Ports:
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  ADDR_WIDTH  transfer address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HBURST  in  3  accepted and ignored; every beat is handled independently.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADY  in  1  bus-level ready (from the slave mux).
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  DATA_WIDTH  read data.

Behaviour:
- Reset (async, any state): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, latched phase registers cleared. SRAM contents are not reset.
- Address-phase accept: on a rising edge with HSEL & HREADY & HTRANS[1]=1, latch HADDR offset, HWRITE and HSIZE, and classify the transfer.
  - ERROR if offset >= MEM_DEPTH*4.
  - ERROR if HSIZE > 010.
  - ERROR if misaligned: halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
  - Otherwise legal.
- IDLE/BUSY, or HSEL=0, with HREADY=1: no accept. The next cycle is a zero-wait OKAY (HREADYOUT=1, HRESP=0). No memory access.
- FSM states and transitions:
  - IDLE (no active data phase): legal accept with WAIT_STATES>0 -> WAIT; legal accept with WAIT_STATES=0 -> DATA; illegal accept -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter counts WAIT_STATES cycles, then -> DATA.
  - DATA: HREADYOUT=1, HRESP=0. Write commits on the closing edge of this cycle. Read data is valid on HRDATA in this cycle. Next state is chosen by the accept rule (back-to-back transfers supported), else -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. No memory access. Next state by the accept rule, else -> IDLE.
- Accepts are only possible when HREADY=1, so no new address is sampled while this slave holds HREADYOUT low.
- Writes, little-endian byte lanes:
  - byte: lane HADDR[1:0].
  - halfword: lanes {HADDR[1],0} and {HADDR[1],1}.
  - word: all four lanes.
  - Unselected lanes are unchanged. Word index = offset[log2(MEM_DEPTH)+1:2].
- Reads:
  - HRDATA = full addressed word (no lane masking) while in DATA. HRDATA = 0 in IDLE, WAIT, ERR1 and ERR2.
  - A read whose address phase overlaps a write's data phase to the same word returns the newly written data.
- Arbitration bubbles: HSEL dropping during WAIT does not abort the current data phase.
- Reset mid-transfer: the in-flight write is dropped with no partial lane update, and outputs return to their reset values immediately.

Test Plan:
1. Reset, WAIT_STATES=1, word write 0xDEADBEEF to 0xEEEE_0010, then word read of the same address -> write data phase shows HREADYOUT 0,1; read returns 0xDEADBEEF with HRESP=0.
2. Word 0x11223344 at 0xEEEE_0020, then byte write 0xAA to 0xEEEE_0022, then halfword write 0x5566 to 0xEEEE_0020 -> final word read returns 0x11AA5566.
3. Word read of 0xEEEE_0400 (offset = MEM_DEPTH*4), then halfword at 0xEEEE_0001, then HSIZE=011 -> each gets ERROR: HREADYOUT 0 then 1 with HRESP=1 on both cycles; memory is unchanged.
4. WAIT_STATES=0: back-to-back NONSEQ write 0x0000_00FF to 0xEEEE_0004 followed immediately by a read of 0xEEEE_0004 -> both zero-wait; read returns 0x0000_00FF.
5. HTRANS=IDLE with HSEL=1, and HTRANS=BUSY mid-burst -> HREADYOUT=1, HRESP=0, HRDATA=0, no memory change.
6. Assert HRESET during the WAIT cycle of a word write of 0x12345678 to 0xEEEE_0008 (prior contents 0) -> HREADYOUT=1 and HRESP=0 immediately; a read after release returns 0x00000000.
